// File: rtl/crc32_frame_engine.sv
// CRC-32 frame engine: drains a fixed-length frame of words from a show-ahead FIFO,
// computes the CRC with a 32-bit-per-cycle unrolled update, and offers it on valid/ready.
module crc32_frame_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
  parameter bit          REFLECT    = 1'b1
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  busy,
  output logic [31:0]           crc_out,
  output logic                  crc_valid,
  input  logic                  crc_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] POLY_REFL = bit_reverse(POLY);

  // Full 32 bit-steps unrolled into one combinational update.
  function automatic logic [31:0] crc_word(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 32; i++) begin
      if (REFLECT) begin
        fb = c[0] ^ d[i];
        c  = {1'b0, c[31:1]} ^ (fb ? POLY_REFL : 32'h0);
      end else begin
        fb = c[31] ^ d[31-i];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [31:0]          crc_q, crc_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]          crc_out_q, crc_out_d;
  logic                 crc_valid_q, crc_valid_d;
  logic [31:0]          word;
  logic [31:0]          crc_next;

  assign word       = fifo_data[31:0];
  assign crc_next   = crc_word(crc_q, word);
  assign fifo_rd_en = (state_q == StRun) && !fifo_empty && !abort;
  assign busy       = (state_q != StIdle);
  assign crc_out    = crc_out_q;
  assign crc_valid  = crc_valid_q;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    remaining_d = remaining_q;
    crc_out_d   = crc_out_q;
    crc_valid_d = crc_valid_q;

    if (abort) begin
      state_d     = StIdle;
      crc_valid_d = 1'b0;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (frame_len != '0) begin
              remaining_d = frame_len;
              crc_d       = INIT;
              state_d     = StRun;
            end else begin
              crc_out_d   = INIT ^ XOROUT;
              crc_valid_d = 1'b1;
              state_d     = StDone;
            end
          end
        end
        StRun: begin
          if (fifo_rd_en) begin
            crc_d       = crc_next;
            remaining_d = remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
              crc_out_d   = crc_next ^ XOROUT;
              crc_valid_d = 1'b1;
              state_d     = StDone;
            end
          end
        end
        StDone: begin
          if (crc_ready) begin
            crc_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= StIdle;
      crc_q       <= INIT;
      remaining_q <= '0;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      remaining_q <= remaining_d;
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
    end
  end

endmodule

// File: doc/crc32_frame_engine.md
Name: crc32_frame_engine

Overview:
CRC-32 engine in the r_clk domain, directly downstream of the asynchronous write/read FIFO. It drains a fixed-length frame of 32-bit words from the FIFO's show-ahead read port and computes a CRC over that frame. It then presents the result on a valid/ready handshake to the status/AXI logic. One frame is processed at a time, at a throughput of one word per cycle whenever the FIFO is non-empty.

Parameters:
DATA_WIDTH, 32, FIFO word width; only 32 is supported.
LEN_WIDTH, 16, width of the frame length in words.
POLY, 32'h04C11DB7, generator polynomial in normal (MSB-first) form.
INIT, 32'hFFFFFFFF, CRC register value at frame start.
XOROUT, 32'hFFFFFFFF, value XORed onto the final CRC.
REFLECT, 1, 1 selects reflected input/output (Ethernet CRC-32); 0 selects non-reflected.

Ports:
r_clk  in  1  clock; all logic is on the rising edge.
rrst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
frame_len  in  LEN_WIDTH  frame length in words; sampled together with start.
abort  in  1  synchronous abort; returns the block to IDLE from any state.
fifo_data  in  DATA_WIDTH  FIFO show-ahead head word; valid whenever fifo_empty=0.
fifo_empty  in  1  FIFO empty flag, r_clk domain.
fifo_rd_en  out  1  pop request; a word is consumed on every edge where this is 1.
busy  out  1  high in RUN and DONE.
crc_out  out  32  final CRC; meaningful only while crc_valid=1.
crc_valid  out  1  result-valid flag.
crc_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: reset is rrst_n, asynchronous, active-low; clock is r_clk. On reset: state=IDLE, crc_out=0, crc_valid=0, busy=0, fifo_rd_en=0, internal crc=INIT, remaining count=0.
- FSM states: IDLE, RUN, DONE. The state is registered.
- IDLE:
  - start=1 with frame_len!=0: latch remaining=frame_len, set crc=INIT, go to RUN.
  - start=1 with frame_len=0: go to DONE with crc_out=INIT^XOROUT (0x00000000 at defaults).
- RUN:
  - fifo_rd_en = ~fifo_empty & ~abort. This is combinational and is forced to 0 outside RUN.
  - On each edge with fifo_rd_en=1: crc <= f(crc, fifo_data) and remaining <= remaining-1.
  - fifo_empty=1 stalls the block with no state change and no read.
  - Consuming the word with remaining==1 moves to DONE. On that same edge crc_out <= final(f(crc, word)) and crc_valid <= 1.
- Word update, REFLECT=1:
  - Bytes are processed in the order [7:0], [15:8], [23:16], [31:24].
  - Each byte is shifted LSB-first into a right-shifting register using the reflected POLY, 32'hEDB88320.
  - final = crc ^ XOROUT.
- Word update, REFLECT=0:
  - Bits are processed from bit 31 down to bit 0 into a left-shifting register using POLY.
  - final = crc ^ XOROUT.
- Implementation: f is a single-cycle combinational unroll of 32 bit-steps. There is no multi-cycle iteration.
- DONE:
  - crc_valid and crc_out are held stable until an edge with crc_ready=1, then the block returns to IDLE with crc_valid=0.
  - A start pulse on the same edge as the handshake is ignored; start is honoured only from IDLE.
- Latency: crc_valid is high on the cycle after the edge that consumes the last word. For a frame length N with the FIFO never empty, start → crc_valid takes N+1 cycles.
- start while busy: ignored; frame_len is not re-latched.
- abort: at the next edge go to IDLE with crc_valid=0, no pop in that cycle, and remaining cleared. abort has priority over start, crc_ready and pops.
- Reset mid-frame: immediate return to the reset values. FIFO words already popped are lost; the FIFO does not re-supply them.
- Remaining count: never underflows. The lowest value it decrements from is 1.
- No pop occurs while fifo_empty=1 in any state.

Test Plan:
- Single word: start, frame_len=1, fifo_data=32'h00000000, FIFO non-empty → exactly 1 pop; crc_valid one cycle later with crc_out=32'h2144DF1C.
- Two words with a stall:
  - Words 32'h34333231 then 32'h38373635 ("12345678").
  - fifo_empty=1 for 3 cycles between the two words.
  - Expect exactly 2 pops, no pops while empty, and crc_out=32'h9AE0DAAF.
- Handshake hold: frame_len=1, word 32'h34333231, crc_ready=0 for 5 cycles → crc_valid stays 1 with crc_out=32'h9BE3E0A3 throughout; deasserts one cycle after crc_ready=1; a start pulse while in DONE is ignored.
- Zero length: frame_len=0 → no pops; crc_valid next cycle with crc_out=32'h00000000.
- Abort: frame_len=4, abort after 2 pops → IDLE next edge; no further pops; crc_valid never asserted. A new start with frame_len=1 and word 0 then yields 32'h2144DF1C.
- Reset mid-frame: assert rrst_n low during RUN → busy, crc_valid and fifo_rd_en all go to 0 immediately, asynchronously to r_clk.
